// File: rtl/e_mdu_pkg.sv
// e_mdu_pkg: shared definitions for the EX-stage multiply/divide unit.
//   - MDU opcode constants (MDU_NONE .. MDU_MFLO), as decoded by the controller
//   - default busy-cycle counts and counter width
//   - FSM state type, HI/LO result struct and the combinational arithmetic helper
package e_mdu_pkg;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;
  localparam logic [3:0] MDU_MFHI  = 4'd7;
  localparam logic [3:0] MDU_MFLO  = 4'd8;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W           = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  function automatic logic is_start_op(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  // HI/LO result of a start op. Divide-by-zero is handled by the caller;
  // here the divisor is forced to 1 so the expression never yields X.
  function automatic hilo_t mdu_compute(input logic [3:0]  op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    hilo_t       r;
    logic [63:0] p;
    logic [31:0] ua;
    logic [31:0] ub;
    logic [31:0] q;
    logic [31:0] rm;
    r  = '0;
    p  = '0;
    ua = a;
    ub = b;
    q  = '0;
    rm = '0;
    case (op)
      MDU_MULT: begin
        // sign-extended operands: the low 64 bits of the unsigned product
        // equal the two's-complement signed product
        p    = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        r.hi = p[63:32];
        r.lo = p[31:0];
      end
      MDU_MULTU: begin
        p    = {32'd0, a} * {32'd0, b};
        r.hi = p[63:32];
        r.lo = p[31:0];
      end
      MDU_DIV: begin
        // magnitude divide, then fix signs: quotient truncates toward zero,
        // remainder follows the dividend. 0x80000000 / -1 wraps to 0x80000000.
        ua   = a[31] ? (~a + 32'd1) : a;
        ub   = b[31] ? (~b + 32'd1) : b;
        if (ub == 32'd0) ub = 32'd1;
        q    = ua / ub;
        rm   = ua % ub;
        r.lo = (a[31] ^ b[31]) ? (~q + 32'd1) : q;
        r.hi = a[31] ? (~rm + 32'd1) : rm;
      end
      MDU_DIVU: begin
        if (ub == 32'd0) ub = 32'd1;
        r.lo = ua / ub;
        r.hi = ua % ub;
      end
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/e_mdu_if.sv
// e_mdu_if: EX-stage MDU bus.
//   E_MDUOP   op code (see e_mdu_pkg)      E_RD1/E_RD2  operands rs/rt
//   E_Start   start strobe to hazard unit   E_Busy       unit busy
//   E_HI/E_LO architectural HI/LO           E_MDUOut     mfhi/mflo read value
// master: pipeline side driving ops/operands; slave: the MDU.
interface e_mdu_if;
  logic [3:0]  E_MDUOP;
  logic [31:0] E_RD1;
  logic [31:0] E_RD2;
  logic        E_Start;
  logic        E_Busy;
  logic [31:0] E_HI;
  logic [31:0] E_LO;
  logic [31:0] E_MDUOut;

  modport master (
    output E_MDUOP, E_RD1, E_RD2,
    input  E_Start, E_Busy, E_HI, E_LO, E_MDUOut
  );

  modport slave (
    input  E_MDUOP, E_RD1, E_RD2,
    output E_Start, E_Busy, E_HI, E_LO, E_MDUOut
  );
endinterface

// File: rtl/e_mdu.sv
// e_mdu: multi-cycle multiply/divide unit owning HI/LO.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-low reset
//   mdu    e_mdu_if.slave (op, operands, start/busy, HI/LO, read value)
// The result is computed combinationally when an op starts and parked in
// pend_hi/pend_lo; the down-counter only models the multi-cycle latency.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | accepts mult/multu/div/divu (start) and mthi/mtlo writes
// ST_BUSY | counting down; HI/LO <= pending result on the cnt==1 edge
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic  clk,
  input  logic  reset,
  e_mdu_if.slave mdu
);

  mdu_state_e       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [31:0]      hi, hi_nx;
  logic [31:0]      lo, lo_nx;
  logic [31:0]      pend_hi, pend_hi_nx;
  logic [31:0]      pend_lo, pend_lo_nx;
  logic             start;
  hilo_t            res;

  assign start = (state == ST_IDLE) && is_start_op(mdu.E_MDUOP);
  assign res   = mdu_compute(mdu.E_MDUOP, mdu.E_RD1, mdu.E_RD2);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      hi      <= hi_nx;
      lo      <= lo_nx;
      pend_hi <= pend_hi_nx;
      pend_lo <= pend_lo_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    hi_nx      = hi;
    lo_nx      = lo;
    pend_hi_nx = pend_hi;
    pend_lo_nx = pend_lo;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx = ST_BUSY;
          cnt_nx   = is_div_op(mdu.E_MDUOP) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          // divide by zero: park the current HI/LO so the final write is a no-op
          if (is_div_op(mdu.E_MDUOP) && (mdu.E_RD2 == 32'd0)) begin
            pend_hi_nx = hi;
            pend_lo_nx = lo;
          end else begin
            pend_hi_nx = res.hi;
            pend_lo_nx = res.lo;
          end
        end else if (mdu.E_MDUOP == MDU_MTHI) begin
          hi_nx = mdu.E_RD1;
        end else if (mdu.E_MDUOP == MDU_MTLO) begin
          lo_nx = mdu.E_RD1;
        end
      end
      ST_BUSY: begin
        cnt_nx = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_nx = ST_IDLE;
          hi_nx    = pend_hi;
          lo_nx    = pend_lo;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    case (mdu.E_MDUOP)
      MDU_MFHI: mdu.E_MDUOut = hi;
      MDU_MFLO: mdu.E_MDUOut = lo;
      default:  mdu.E_MDUOut = 32'd0;
    endcase
  end

  assign mdu.E_Start = start;
  assign mdu.E_Busy  = (state == ST_BUSY);
  assign mdu.E_HI    = hi;
  assign mdu.E_LO    = lo;

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Multi-cycle multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the EX-stage operands E_RD1 (rs) and E_RD2 (rt) plus a decoded MDU opcode.
- Owns the architectural HI/LO registers and reports start/busy to the hazard unit, which stalls MDU-class instructions in ID.
- Supplies the mfhi/mflo read value to the EX result mux.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1).
- DIV_CYCLES, 10, busy cycles for div/divu (>=1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset; sampled at the rising edge of clk, reset==0 resets.
- E_MDUOP  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9-15 treated as none.
- E_RD1  in  32  operand A (rs).
- E_RD2  in  32  operand B (rt).
- E_Start  out  1  combinational; 1 when E_MDUOP is 1..4 and state==IDLE.
- E_Busy  out  1  registered; 1 while state==BUSY.
- E_HI  out  32  HI register.
- E_LO  out  32  LO register.
- E_MDUOut  out  32  combinational; E_HI if op==mfhi, E_LO if op==mflo, else 0.

Behaviour:
- Reset (reset==0 at edge):
  - state=IDLE, cnt=0, HI=0, LO=0, pending results=0, E_Busy=0.
  - Overrides any in-flight operation, which is aborted with no HI/LO write.
- States: IDLE and BUSY.
  - cnt is a 4-bit down-counter, sized to hold max(MULT_CYCLES, DIV_CYCLES).
  - pend_hi and pend_lo are 32-bit registers.
- IDLE, op 1..4 (edge ending cycle T):
  - Compute result from E_RD1/E_RD2 into pend_hi/pend_lo.
  - cnt = MULT_CYCLES or DIV_CYCLES; state=BUSY.
- BUSY:
  - E_Busy=1 in cycles T+1 .. T+N (N = cycle count).
  - Each edge decrements cnt.
  - At the edge where cnt==1: HI=pend_hi, LO=pend_lo, state=IDLE.
  - New HI/LO are visible in cycle T+N+1.
- Latency: a mfhi issued right behind mult stalls in ID until E_Busy falls; the hazard unit stalls on (E_Start | E_Busy).
- Arithmetic:
  - mult/multu: 64-bit product, signed or unsigned; HI=[63:32], LO=[31:0].
  - div: signed; quotient truncates toward zero; remainder takes the sign of the dividend; LO=quotient, HI=remainder.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - divu: unsigned.
  - Divide by zero (div/divu with B==0): takes full DIV_CYCLES; HI/LO unchanged.
- mthi/mtlo in IDLE: HI (or LO) = E_RD1 at the edge; visible next cycle.
- Any op 1..6 while BUSY: ignored, no state change. The hazard unit guarantees this never occurs; the bench flags it as an error.
- mfhi/mflo while BUSY: returns the old HI/LO. The hazard unit must prevent this case.
- E_MDUOut is a pure read; mfhi/mflo never change state.
- No flush input: once started, an operation always completes unless reset.

Decomposition:
- Shared package/header mdu_def: opcode constants MDU_NONE..MDU_MFLO, and the default cycle counts.
- The Controller decodes E_MDUOP from the instruction using these constants.
- No sub-module: the datapath is inline, a 64-bit multiply and 32-bit divide/remainder computed combinationally at start.
- Multi-cycle timing is modelled by the counter only.

Test Plan:
- Reset:
  - Stimulus: hold reset=0 two cycles, then release.
  - Required: E_HI=E_LO=0, E_Busy=0, E_Start=0 with op=none.
- mult signed:
  - Stimulus: op=mult, A=0xFFFFFFFF, B=2 in cycle T.
  - Required: E_Start=1 in T; E_Busy=1 for T+1..T+5; in T+6 HI=0xFFFFFFFF, LO=0xFFFFFFFE, E_Busy=0.
- multu same operands:
  - Required: HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- div signed:
  - Stimulus: A=-7 (0xFFFFFFF9), B=2.
  - Required: after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu 7/0 after mthi 0x1234 / mtlo 0x5678: 10 busy cycles, then HI=0x1234, LO=0x5678.
- mthi/mflo path:
  - Stimulus: mthi A=0xDEADBEEF, then mfhi next cycle.
  - Required: E_MDUOut=0xDEADBEEF; mflo returns the unchanged LO.
- Reset mid-operation:
  - Stimulus: start div, assert reset=0 at the 4th busy cycle.
  - Required: next cycle E_Busy=0, HI=LO=0; a following multu 3*4 yields LO=12, HI=0 after 5 cycles.
